// File: rtl/page_controller.sv
// Screen sequencer for the escape-room VGA game: walks TITLE -> PLAY -> GAP -> DONE,
// tracks the current level and muxes the three page renderers onto one rgb bus.
module page_controller #(
    parameter int NUM_LEVELS  = 3,
    parameter int GAP_FRAMES  = 120,
    parameter int DONE_FRAMES = 600,
    parameter int LVL_W       = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_start,
    input  logic             level_done,
    input  logic             frame_tick,
    input  logic             video_on,
    input  logic [11:0]      rgb_title,
    input  logic [11:0]      rgb_game,
    input  logic [11:0]      rgb_done,
    output logic [11:0]      rgb,
    output logic [1:0]       page,
    output logic [LVL_W-1:0] level,
    output logic             game_en,
    output logic             level_start
);

    localparam int CNT_MAX = (GAP_FRAMES > DONE_FRAMES) ? GAP_FRAMES : DONE_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_FRAMES - 1);
    localparam logic [CNT_W-1:0] DONE_LAST = CNT_W'(DONE_FRAMES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT   = '1;
    localparam logic [LVL_W-1:0] LVL_LAST  = LVL_W'(NUM_LEVELS - 1);

    typedef enum logic [1:0] {
        TITLE = 2'd0,
        PLAY  = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [LVL_W-1:0] level_next;
    logic             level_start_next;

    logic btn_meta;
    logic btn_sync;
    logic btn_prev;
    logic start_p;

    function automatic logic [11:0] pixel_mux(input logic [1:0]  pg,
                                              input logic [11:0] pix_title,
                                              input logic [11:0] pix_game,
                                              input logic [11:0] pix_done);
        logic [11:0] pix;
        unique case (pg)
            2'd0:    pix = pix_title;
            2'd3:    pix = pix_done;
            default: pix = pix_game;
        endcase
        return pix;
    endfunction

    // Synchronizer stage: two flops into the clock domain plus one for edge detect
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
            btn_prev <= 1'b0;
        end else begin
            btn_meta <= btn_start;
            btn_sync <= btn_meta;
            btn_prev <= btn_sync;
        end
    end

    assign start_p = btn_sync & ~btn_prev;

    always_comb begin
        state_next       = state;
        cnt_next         = cnt;
        level_next       = level;
        level_start_next = 1'b0;
        unique case (state)
            TITLE: begin
                if (start_p) begin
                    state_next       = PLAY;
                    level_next       = '0;
                    level_start_next = 1'b1;
                    cnt_next         = '0;
                end
            end
            PLAY: begin
                if (level_done) begin
                    cnt_next   = '0;
                    state_next = (level == LVL_LAST) ? DONE : GAP;
                end
            end
            GAP: begin
                if (frame_tick) begin
                    if (cnt == GAP_LAST) begin
                        state_next       = PLAY;
                        level_next       = (level == LVL_LAST) ? level : level + LVL_W'(1);
                        level_start_next = 1'b1;
                        cnt_next         = '0;
                    end else if (cnt != CNT_SAT) begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                if (start_p || (frame_tick && cnt == DONE_LAST)) begin
                    state_next = TITLE;
                    level_next = '0;
                    cnt_next   = '0;
                end else if (frame_tick && cnt != CNT_SAT) begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: state_next = TITLE;
        endcase
    end

    // Sequencer stage: page only follows state on frame boundaries
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= TITLE;
            cnt         <= '0;
            level       <= '0;
            level_start <= 1'b0;
            game_en     <= 1'b0;
            page        <= 2'd0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            level       <= level_next;
            level_start <= level_start_next;
            game_en     <= (state_next == PLAY);
            if (frame_tick) begin
                page <= state;
            end
        end
    end

    // Pixel output stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb <= 12'h000;
        end else begin
            rgb <= video_on ? pixel_mux(page, rgb_title, rgb_game, rgb_done) : 12'h000;
        end
    end

endmodule

// File: tb/tb_page_controller.sv
// Bench for page_controller: a frame-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_page_controller;

    localparam int NUM_LEVELS  = 3;
    localparam int GAP_FRAMES  = 120;
    localparam int DONE_FRAMES = 600;

    logic        clk = 1'b0;
    logic        reset;
    logic        btn_start = 1'b0;
    logic        level_done = 1'b0;
    logic        frame_tick = 1'b0;
    logic        video_on = 1'b1;
    logic [11:0] rgb_title = 12'hA00;
    logic [11:0] rgb_game  = 12'h0B0;
    logic [11:0] rgb_done  = 12'h00C;
    logic [11:0] rgb;
    logic [1:0]  page;
    logic [1:0]  level;
    logic        game_en;
    logic        level_start;

    int n_assert = 0;
    int n_fail   = 0;

    page_controller #(
        .NUM_LEVELS (NUM_LEVELS),
        .GAP_FRAMES (GAP_FRAMES),
        .DONE_FRAMES(DONE_FRAMES),
        .LVL_W      (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_start  (btn_start),
        .level_done (level_done),
        .frame_tick (frame_tick),
        .video_on   (video_on),
        .rgb_title  (rgb_title),
        .rgb_game   (rgb_game),
        .rgb_done   (rgb_done),
        .rgb        (rgb),
        .page       (page),
        .level      (level),
        .game_en    (game_en),
        .level_start(level_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: game phase, frames elapsed in that phase, shown page.
    int          m_phase;
    int          m_frames;
    int          m_level;
    int          m_page;
    logic        m_game_en;
    logic        m_level_start;
    logic [11:0] m_rgb;
    logic [2:0]  m_hist;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase <= 0; m_frames <= 0; m_level <= 0; m_page <= 0;
            m_game_en <= 1'b0; m_level_start <= 1'b0; m_rgb <= 12'h000; m_hist <= 3'b000;
        end else begin
            int   nxt;
            int   fr;
            int   lv;
            logic ls;
            logic start;
            start = m_hist[1] & ~m_hist[2];
            nxt = m_phase; fr = m_frames; lv = m_level; ls = 1'b0;
            case (m_phase)
                0: if (start) begin nxt = 1; lv = 0; ls = 1'b1; fr = 0; end
                1: if (level_done) begin fr = 0; nxt = (lv == NUM_LEVELS - 1) ? 3 : 2; end
                2: if (frame_tick) begin
                    fr = fr + 1;
                    if (fr == GAP_FRAMES) begin nxt = 1; lv = lv + 1; ls = 1'b1; fr = 0; end
                end
                default: if (start) begin nxt = 0; lv = 0; fr = 0; end
                    else if (frame_tick) begin
                        fr = fr + 1;
                        if (fr == DONE_FRAMES) begin nxt = 0; lv = 0; fr = 0; end
                    end
            endcase
            if (frame_tick) m_page <= m_phase;
            if (!video_on) m_rgb <= 12'h000;
            else if (m_page == 0) m_rgb <= rgb_title;
            else if (m_page == 3) m_rgb <= rgb_done;
            else m_rgb <= rgb_game;
            m_phase <= nxt; m_frames <= fr; m_level <= lv;
            m_game_en <= (nxt == 1); m_level_start <= ls;
            m_hist <= {m_hist[1:0], btn_start};
        end
    end

    always @(negedge clk) begin
        check("rgb", 32'(rgb), 32'(m_rgb));
        check("page", 32'(page), 32'(m_page));
        check("level", 32'(level), 32'(m_level));
        check("game_en", 32'(game_en), 32'(m_game_en));
        check("level_start", 32'(level_start), 32'(m_level_start));
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            frame_tick = 1'b1; cyc(1);
            frame_tick = 1'b0; cyc(3);
        end
    endtask

    task automatic pulse_level_done();
        level_done = 1'b1; cyc(1);
        level_done = 1'b0; cyc(2);
    endtask

    task automatic press();
        btn_start = 1'b1; cyc(4);
        btn_start = 1'b0; cyc(3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        cyc(3);
        check("reset_page", 32'(page), 0);
        check("reset_level", 32'(level), 0);
        check("reset_game_en", 32'(game_en), 0);
        check("reset_level_start", 32'(level_start), 0);
        check("reset_rgb", 32'(rgb), 0);
        reset = 1'b0;
        cyc(2);
        check("title_rgb", 32'(rgb), 32'h A00);

        // T1: start edge seen on the third clock
        btn_start = 1'b1;
        cyc(3);
        check("t1_level_start", 32'(level_start), 1);
        check("t1_game_en", 32'(game_en), 1);
        check("t1_level", 32'(level), 0);
        check("t1_page_held", 32'(page), 0);
        cyc(1);
        check("t1_ls_one_cycle", 32'(level_start), 0);
        btn_start = 1'b0;
        cyc(3);
        tick_n(1);
        check("t1_page_play", 32'(page), 1);
        check("t1_rgb_game", 32'(rgb), 32'h0B0);

        // T2: gap between levels
        level_done = 1'b1; cyc(1); level_done = 1'b0;
        check("t2_game_en_drop", 32'(game_en), 0);
        cyc(2);
        tick_n(GAP_FRAMES - 1);
        check("t2_page_gap", 32'(page), 2);
        check("t2_level_hold", 32'(level), 0);
        frame_tick = 1'b1; cyc(1); frame_tick = 1'b0;
        check("t2_level1", 32'(level), 1);
        check("t2_level_start", 32'(level_start), 1);
        check("t2_page_pre", 32'(page), 2);
        cyc(3);
        tick_n(1);
        check("t2_page_play", 32'(page), 1);

        pulse_level_done();
        tick_n(GAP_FRAMES);
        check("lvl2", 32'(level), 2);

        // T5: level_done together with frame_tick keeps the old page
        frame_tick = 1'b1; level_done = 1'b1; cyc(1);
        frame_tick = 1'b0; level_done = 1'b0;
        check("t5_page_old", 32'(page), 1);
        check("t5_game_en", 32'(game_en), 0);
        cyc(3);
        tick_n(1);
        check("t3_page_done", 32'(page), 3);
        check("t3_rgb_done", 32'(rgb), 32'h00C);

        // T6: blanking forces black
        rgb_done = 12'hFFF; video_on = 1'b0; cyc(2);
        check("t6_blank", 32'(rgb), 0);
        video_on = 1'b1; cyc(2);
        check("t6_unblank", 32'(rgb), 32'hFFF);
        rgb_done = 12'h00C;

        // T3: done timeout (one DONE frame already counted)
        tick_n(DONE_FRAMES - 2);
        check("t3_still_done", 32'(page), 3);
        frame_tick = 1'b1; cyc(1); frame_tick = 1'b0;
        check("t3_level0", 32'(level), 0);
        check("t3_page_pre", 32'(page), 3);
        cyc(3);
        tick_n(1);
        check("t3_page_title", 32'(page), 0);

        // T5: level_done in TITLE ignored
        pulse_level_done();
        tick_n(1);
        check("t5_title_ignore", 32'(game_en), 0);
        check("t5_title_page", 32'(page), 0);

        // T4: button in DONE, held high gives one start only
        press();
        tick_n(1);
        pulse_level_done(); tick_n(GAP_FRAMES);
        pulse_level_done(); tick_n(GAP_FRAMES);
        pulse_level_done(); tick_n(1);
        check("t4_in_done", 32'(page), 3);
        btn_start = 1'b1; cyc(3);
        check("t4_level0", 32'(level), 0);
        cyc(50);
        check("t4_one_start", 32'(game_en), 0);
        tick_n(1);
        check("t4_page_title", 32'(page), 0);
        btn_start = 1'b0; cyc(3);

        // T6: async reset during GAP
        press();
        pulse_level_done();
        tick_n(5);
        check("t6_in_gap", 32'(page), 2);
        reset = 1'b1; #1;
        check("t6_rst_page", 32'(page), 0);
        check("t6_rst_level", 32'(level), 0);
        check("t6_rst_game_en", 32'(game_en), 0);
        check("t6_rst_rgb", 32'(rgb), 0);
        cyc(2);
        reset = 1'b0;
        cyc(3);
        check("t6_no_ls", 32'(level_start), 0);
        check("t6_title", 32'(game_en), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
